// File: rtl/vs_stream_demux.sv
// Packet-aware 1:N valid/ready demux; destination latched on the first beat and held until s_last.
// Latency 1 cycle (registered outputs), s_ready follows m_ready[dest]; VS_DEMUX_DROP_EN drops out-of-range packets.
module vs_stream_demux #(
  parameter int WIDTH = 8,
  parameter int N_OUT = 4,
  parameter int SEL_W = $clog2(N_OUT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [SEL_W-1:0] select,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic [N_OUT-1:0] m_valid,
  input  logic [N_OUT-1:0] m_ready,
  output logic [WIDTH-1:0] m_data,
  output logic             m_last,
  output logic [7:0]       drop_count
);

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } beat_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  localparam logic [SEL_W:0]   NOUT_EXT = N_OUT[SEL_W:0];
  localparam int               LAST_I   = N_OUT - 1;
  localparam logic [SEL_W-1:0] LAST_IDX = LAST_I[SEL_W-1:0];

  state_t           state, state_nxt;
  logic             full;
  logic [SEL_W-1:0] dest;
  logic [SEL_W-1:0] cur_dest;
  beat_t            beat_q;

  logic             sel_oor;
  logic             first_beat;
  logic             drop_beat;
  logic [SEL_W-1:0] beat_dest;
  logic             dest_rdy;
  logic             accept;
  logic             load;

  assign sel_oor = {1'b0, select} >= NOUT_EXT;

  // Decode the held destination into the one-hot valid and its ready.
  always_comb begin
    dest_rdy = 1'b0;
    m_valid  = '0;
    for (int i = 0; i < N_OUT; i++) begin
      if (dest == i[SEL_W-1:0]) begin
        dest_rdy   = m_ready[i];
        m_valid[i] = full;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept && !s_last) begin
          state_nxt = drop_beat ? ST_DROP : ST_BUSY;
        end
      end
      ST_BUSY, ST_DROP: begin
        if (accept && s_last) begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    first_beat = (state == ST_IDLE);
    drop_beat  = 1'b0;
    beat_dest  = cur_dest;
    if (first_beat) begin
      beat_dest = sel_oor ? LAST_IDX : select;
    end
`ifdef VS_DEMUX_DROP_EN
    drop_beat = (state == ST_DROP) || (first_beat && sel_oor);
`endif
  end

  // Dropped beats never touch the output register, so they need no room in it.
  assign s_ready = !rst && (drop_beat || !full || dest_rdy);
  assign accept  = s_valid && s_ready;
  assign load    = accept && !drop_beat;

  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      dest     <= '0;
      cur_dest <= '0;
      beat_q   <= '0;
    end else begin
      if (load) begin
        full   <= 1'b1;
        dest   <= beat_dest;
        beat_q <= '{last: s_last, data: s_data};
      end else if (full && dest_rdy) begin
        full <= 1'b0;
      end
      if (load && first_beat) begin
        cur_dest <= beat_dest;
      end
    end
  end

  assign m_data = beat_q.data;
  assign m_last = beat_q.last;

`ifdef VS_DEMUX_DROP_EN
  logic [7:0] drop_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      drop_q <= 8'd0;
    end else if (accept && first_beat && drop_beat && (drop_q != 8'hFF)) begin
      drop_q <= drop_q + 8'd1;
    end
  end

  assign drop_count = drop_q;
`else
  assign drop_count = 8'd0;
`endif

endmodule

// File: tb/tb_vs_stream_demux.sv
// Directed bench for vs_stream_demux: a 4-channel instance for routing/backpressure and a 3-channel one for out-of-range select.
module tb_vs_stream_demux;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;

  logic [1:0] sel4;
  logic       sv4, sr4, sl4, ml4;
  logic [7:0] sd4, md4, dc4;
  logic [3:0] mv4, mr4;

  logic [1:0] sel3;
  logic       sv3, sr3, sl3, ml3;
  logic [7:0] sd3, md3, dc3;
  logic [2:0] mv3, mr3;

  int checks = 0;
  int errors = 0;

  vs_stream_demux #(.WIDTH(8), .N_OUT(4)) u4 (
    .clk(clk), .rst(rst), .select(sel4), .s_valid(sv4), .s_ready(sr4),
    .s_data(sd4), .s_last(sl4), .m_valid(mv4), .m_ready(mr4),
    .m_data(md4), .m_last(ml4), .drop_count(dc4)
  );

  vs_stream_demux #(.WIDTH(8), .N_OUT(3)) u3 (
    .clk(clk), .rst(rst), .select(sel3), .s_valid(sv3), .s_ready(sr3),
    .s_data(sd3), .s_last(sl3), .m_valid(mv3), .m_ready(mr3),
    .m_data(md3), .m_last(ml3), .drop_count(dc3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  initial begin
    rst  = 1'b1;
    sel4 = '0; sv4 = 1'b0; sd4 = '0; sl4 = 1'b0; mr4 = 4'hF;
    sel3 = '0; sv3 = 1'b0; sd3 = '0; sl3 = 1'b0; mr3 = 3'h7;
    cyc();
    cyc();

    // Reset state
    chk("rst_mvalid", mv4, 4'b0000);
    chk("rst_mdata", md4, 8'h00);
    chk("rst_mlast", ml4, 1'b0);
    chk("rst_drop", dc4, 8'd0);
    chk("rst_sready", sr4, 1'b0);
    rst = 1'b0;
    settle();
    chk("post_rst_sready", sr4, 1'b1);

    // Open a packet on channel 3, then reset over it for 2 cycles
    sel4 = 2'd3; sv4 = 1'b1; sd4 = 8'h11; sl4 = 1'b0;
    cyc();
    chk("open_mvalid", mv4, 4'b1000);
    chk("open_mdata", md4, 8'h11);
    sv4 = 1'b0; mr4 = 4'b0111; rst = 1'b1;
    settle();
    chk("in_rst_sready0", sr4, 1'b0);
    cyc();
    chk("in_rst_mvalid0", mv4, 4'b0000);
    chk("in_rst_sready1", sr4, 1'b0);
    cyc();
    chk("in_rst_mvalid1", mv4, 4'b0000);
    chk("in_rst_mdata", md4, 8'h00);
    rst = 1'b0; mr4 = 4'hF;
    cyc();
    chk("after_rst_sready", sr4, 1'b1);
    chk("after_rst_mvalid", mv4, 4'b0000);
    // First beat after reset must re-sample select (not stick to channel 3)
    sel4 = 2'd1; sv4 = 1'b1; sd4 = 8'h22; sl4 = 1'b1;
    cyc();
    chk("after_rst_route", mv4, 4'b0010);
    chk("after_rst_data", md4, 8'h22);
    chk("after_rst_last", ml4, 1'b1);
    sv4 = 1'b0; sl4 = 1'b0;
    cyc();
    chk("idle_mvalid", mv4, 4'b0000);

    // Streaming 3-beat packet, select changes mid-packet
    sel4 = 2'd2; sv4 = 1'b1; sd4 = 8'hA0; sl4 = 1'b0;
    cyc();
    chk("stream0_mvalid", mv4, 4'b0100);
    chk("stream0_data", md4, 8'hA0);
    chk("stream0_last", ml4, 1'b0);
    sel4 = 2'd1; sd4 = 8'hA1;
    cyc();
    chk("stream1_mvalid", mv4, 4'b0100);
    chk("stream1_data", md4, 8'hA1);
    chk("stream1_last", ml4, 1'b0);
    sd4 = 8'hA2; sl4 = 1'b1;
    cyc();
    chk("stream2_mvalid", mv4, 4'b0100);
    chk("stream2_data", md4, 8'hA2);
    chk("stream2_last", ml4, 1'b1);
    sv4 = 1'b0; sl4 = 1'b0;
    cyc();
    chk("stream_end_mvalid", mv4, 4'b0000);

    // Backpressure: channel 2 stalls 3 cycles with B1 waiting
    sel4 = 2'd2; sv4 = 1'b1; sd4 = 8'hB0; sl4 = 1'b0;
    cyc();
    chk("bp0_mvalid", mv4, 4'b0100);
    chk("bp0_data", md4, 8'hB0);
    sel4 = 2'd0; sd4 = 8'hB1; mr4 = 4'b1011;
    settle();
    chk("bp_stall_sready0", sr4, 1'b0);
    cyc();
    chk("bp_hold0_data", md4, 8'hB0);
    chk("bp_hold0_mvalid", mv4, 4'b0100);
    mr4 = 4'b1010;
    settle();
    chk("bp_stall_sready1", sr4, 1'b0);
    cyc();
    chk("bp_hold1_data", md4, 8'hB0);
    mr4 = 4'b1011;
    settle();
    chk("bp_stall_sready2", sr4, 1'b0);
    cyc();
    chk("bp_hold2_data", md4, 8'hB0);
    chk("bp_hold2_mvalid", mv4, 4'b0100);
    mr4 = 4'hF;
    settle();
    chk("bp_release_sready", sr4, 1'b1);
    cyc();
    chk("bp1_data", md4, 8'hB1);
    chk("bp1_mvalid", mv4, 4'b0100);
    sd4 = 8'hB2; sl4 = 1'b1;
    cyc();
    chk("bp2_data", md4, 8'hB2);
    chk("bp2_last", ml4, 1'b1);
    sv4 = 1'b0; sl4 = 1'b0;
    cyc();
    chk("bp_end_mvalid", mv4, 4'b0000);

    // Back-to-back single-beat packets to 0, 3, 1
    sv4 = 1'b1; sl4 = 1'b1; sel4 = 2'd0; sd4 = 8'hC0;
    cyc();
    chk("b2b0_mvalid", mv4, 4'b0001);
    chk("b2b0_data", md4, 8'hC0);
    sel4 = 2'd3; sd4 = 8'hC1;
    cyc();
    chk("b2b1_mvalid", mv4, 4'b1000);
    chk("b2b1_data", md4, 8'hC1);
    sel4 = 2'd1; sd4 = 8'hC2;
    cyc();
    chk("b2b2_mvalid", mv4, 4'b0010);
    chk("b2b2_data", md4, 8'hC2);
    sv4 = 1'b0; sl4 = 1'b0;
    cyc();
    chk("b2b_end_mvalid", mv4, 4'b0000);
    chk("n4_drop", dc4, 8'd0);

    // Out-of-range select on the 3-channel instance, 2-beat packet
    sel3 = 2'd3; sv3 = 1'b1; sd3 = 8'hD0; sl3 = 1'b0;
    settle();
    chk("oor_sready0", sr3, 1'b1);
    cyc();
`ifdef VS_DEMUX_DROP_EN
    chk("oor0_mvalid", mv3, 3'b000);
    chk("oor0_drop", dc3, 8'd1);
`else
    chk("oor0_mvalid", mv3, 3'b100);
    chk("oor0_data", md3, 8'hD0);
    chk("oor0_last", ml3, 1'b0);
`endif
    sel3 = 2'd0; sd3 = 8'hD1; sl3 = 1'b1;
    settle();
    chk("oor_sready1", sr3, 1'b1);
    cyc();
`ifdef VS_DEMUX_DROP_EN
    chk("oor1_mvalid", mv3, 3'b000);
    chk("oor1_data", md3, 8'h00);
    chk("oor1_last", ml3, 1'b0);
    chk("oor1_drop", dc3, 8'd1);
`else
    chk("oor1_mvalid", mv3, 3'b100);
    chk("oor1_data", md3, 8'hD1);
    chk("oor1_last", ml3, 1'b1);
    chk("oor1_drop", dc3, 8'd0);
`endif
    sv3 = 1'b0; sl3 = 1'b0;
    cyc();
    chk("oor_end_mvalid", mv3, 3'b000);

`ifdef VS_DEMUX_DROP_EN
    // 253 more single-beat drops -> 254, then 2 more saturate at 255
    sv3 = 1'b1; sl3 = 1'b1; sel3 = 2'd3;
    for (int k = 0; k < 253; k++) begin
      cyc();
    end
    sv3 = 1'b0;
    cyc();
    chk("drop_254", dc3, 8'd254);
    sv3 = 1'b1;
    cyc();
    cyc();
    sv3 = 1'b0;
    cyc();
    chk("drop_sat", dc3, 8'd255);
    chk("drop_sat_mvalid", mv3, 3'b000);
`endif

    // In-range select on the 3-channel instance still routes normally
    sel3 = 2'd1; sv3 = 1'b1; sd3 = 8'hE0; sl3 = 1'b1;
    cyc();
    chk("n3_route_mvalid", mv3, 3'b010);
    chk("n3_route_data", md3, 8'hE0);
    sv3 = 1'b0; sl3 = 1'b0;
    cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
